// File: rtl/sipo_frame_rx_pkg.sv
// sipo_frame_rx shared types: FSM states, line levels, parity helper.
// Optional parity feature is selected with SIPO_FRAME_RX_PARITY_EN.
package sipo_frame_rx_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_PARITY = 2'd2,
        S_STOP   = 2'd3
    } state_t;

    localparam logic DEF_IDLE_LEVEL = 1'b0;
    localparam logic START_BIT      = ~DEF_IDLE_LEVEL;
    localparam logic STOP_BIT       = DEF_IDLE_LEVEL;

    function automatic logic start_bit_of(input logic idle_level);
        return ~idle_level;
    endfunction

    function automatic logic stop_bit_of(input logic idle_level);
        return idle_level;
    endfunction

    // Even-parity bit of a word (zero-extended to 32 bits).
    function automatic logic even_parity(input logic [31:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/sipo_frame_rx_shift.sv
// sipo_shift_core: MSB-first shift register plus bit counter.
// last_bit_o is high while the final data bit of a frame is being taken.
module sipo_shift_core #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear_i,
    input  logic             shift_en_i,
    input  logic             bit_i,
    output logic [WIDTH-1:0] data_o,
    output logic             last_bit_o
);
    import sipo_frame_rx_pkg::*;

    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    assign data_o     = shreg_q;
    assign last_bit_o = (cnt_q == CW'(WIDTH - 1));

    // Next-state for shift register and counter.
    always_comb begin
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        if (clear_i) begin
            shreg_d = '0;
            cnt_d   = '0;
        end else if (shift_en_i) begin
            shreg_d = {shreg_q[WIDTH-2:0], bit_i};
            cnt_d   = last_bit_o ? '0 : cnt_q + 1'b1;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/sipo_frame_rx.sv
// sipo_frame_rx: serial frame receiver with valid/ready output and error flags.
// Define SIPO_FRAME_RX_PARITY_EN to add an even-parity bit after the data.
module sipo_frame_rx #(
    parameter int   WIDTH      = 4,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             sdi,
    input  logic             sdi_en,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overrun,
    input  logic             overrun_clr,
    output logic             frame_err,
    output logic             busy
);
    import sipo_frame_rx_pkg::*;

    localparam logic START_B = start_bit_of(IDLE_LEVEL);
    localparam logic STOP_B  = stop_bit_of(IDLE_LEVEL);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic             overrun_q, overrun_d;
    logic             frame_err_q, frame_err_d;
    logic             shift_en, clear;
    logic             last_bit;
    logic [WIDTH-1:0] shreg;

    sipo_shift_core #(.WIDTH(WIDTH)) u_core (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear_i    (clear),
        .shift_en_i (shift_en),
        .bit_i      (sdi),
        .data_o     (shreg),
        .last_bit_o (last_bit)
    );

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign overrun   = overrun_q;
    assign frame_err = frame_err_q;
    assign busy      = (state_q != S_IDLE);

    // FSM, holding register and flag next-state; advances only on sdi_en.
    always_comb begin
        state_d     = state_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q && !out_ready;
        overrun_d   = overrun_q && !overrun_clr;
        frame_err_d = 1'b0;
        shift_en    = 1'b0;
        clear       = 1'b0;
        if (sdi_en) begin
            case (state_q)
                S_IDLE: begin
                    if (sdi == START_B) begin
                        state_d = S_DATA;
                        clear   = 1'b1;
                    end
                end
                S_DATA: begin
                    shift_en = 1'b1;
                    if (last_bit) begin
`ifdef SIPO_FRAME_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end
                S_PARITY: begin
`ifdef SIPO_FRAME_RX_PARITY_EN
                    if (even_parity(32'(shreg)) ^ sdi) begin
                        frame_err_d = 1'b1;
                        state_d     = S_IDLE;
                    end else begin
                        state_d = S_STOP;
                    end
`else
                    state_d = S_IDLE;
`endif
                end
                S_STOP: begin
                    state_d = S_IDLE;
                    if (sdi == STOP_B) begin
                        if (!out_valid_q || out_ready) begin
                            out_data_d  = shreg;
                            out_valid_d = 1'b1;
                        end else begin
                            overrun_d = 1'b1;
                        end
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
        end
    end

endmodule

// File: tb/tb_sipo_frame_rx.sv
// Directed testbench for sipo_frame_rx (WIDTH=4, IDLE_LEVEL=0).
// Also covers parity frames when SIPO_FRAME_RX_PARITY_EN is defined.
module tb_sipo_frame_rx;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       sdi = 1'b0;
    logic       sdi_en = 1'b0;
    logic       out_ready = 1'b0;
    logic       overrun_clr = 1'b0;
    logic [3:0] out_data;
    logic       out_valid;
    logic       overrun;
    logic       frame_err;
    logic       busy;

    int checks = 0;
    int failures = 0;
    int fe_seen = 0;

    always #5 clk = ~clk;

    sipo_frame_rx #(.WIDTH(4), .IDLE_LEVEL(1'b0)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .sdi         (sdi),
        .sdi_en      (sdi_en),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .overrun     (overrun),
        .overrun_clr (overrun_clr),
        .frame_err   (frame_err),
        .busy        (busy)
    );

    // One clock: drive at negedge, observe 1ns after the posedge.
    task automatic drive(input logic b, input logic en);
        @(negedge clk);
        sdi    = b;
        sdi_en = en;
        @(posedge clk);
        #1;
        if (frame_err === 1'b1) fe_seen++;
    endtask

    // Start, MSB-first data, optional parity, stop (good or bad).
    task automatic send_frame(input logic [3:0] w, input logic stop_ok);
        drive(1'b1, 1'b1);
        for (int i = 3; i >= 0; i--) drive(w[i], 1'b1);
`ifdef SIPO_FRAME_RX_PARITY_EN
        drive(^w, 1'b1);
`endif
        drive(stop_ok ? 1'b0 : 1'b1, 1'b1);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        drive(1'b1, 1'b1);
        drive(1'b0, 1'b1);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL rst_valid got=%b exp=0", out_valid);
        end
        checks++;
        if (out_data !== 4'h0) begin
            failures++;
            $display("FAIL rst_data got=%h exp=0", out_data);
        end
        checks++;
        if (overrun !== 1'b0) begin
            failures++;
            $display("FAIL rst_overrun got=%b exp=0", overrun);
        end
        checks++;
        if (frame_err !== 1'b0) begin
            failures++;
            $display("FAIL rst_frame_err got=%b exp=0", frame_err);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL rst_busy got=%b exp=0", busy);
        end
        reset_n = 1'b1;
        drive(1'b0, 1'b0);
    endtask

    task automatic test_good_frame();
        logic [3:0] bits;
        bits = 4'b1010;
        out_ready = 1'b1;
        drive(1'b1, 1'b1);
        for (int i = 3; i >= 0; i--) begin
            checks++;
            if (busy !== 1'b1) begin
                failures++;
                $display("FAIL good_busy bit=%0d got=%b exp=1", i, busy);
            end
            drive(bits[i], 1'b1);
        end
`ifdef SIPO_FRAME_RX_PARITY_EN
        drive(1'b0, 1'b1);
`endif
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL good_early_valid got=%b exp=0", out_valid);
        end
        drive(1'b0, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 4'hA) begin
            failures++;
            $display("FAIL good_word got=%b/%h exp=1/a", out_valid, out_data);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL good_busy_end got=%b exp=0", busy);
        end
        drive(1'b0, 1'b1);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL good_valid_1clk got=%b exp=0", out_valid);
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        send_frame(4'hA, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 4'hA) begin
            failures++;
            $display("FAIL bp_first got=%b/%h exp=1/a", out_valid, out_data);
        end
        send_frame(4'h5, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 4'hA) begin
            failures++;
            $display("FAIL bp_hold got=%b/%h exp=1/a", out_valid, out_data);
        end
        checks++;
        if (overrun !== 1'b1) begin
            failures++;
            $display("FAIL bp_overrun got=%b exp=1", overrun);
        end
        out_ready = 1'b1;
        drive(1'b0, 1'b0);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_transfer got=%b exp=0", out_valid);
        end
        checks++;
        if (overrun !== 1'b1) begin
            failures++;
            $display("FAIL bp_sticky got=%b exp=1", overrun);
        end
        overrun_clr = 1'b1;
        drive(1'b0, 1'b0);
        overrun_clr = 1'b0;
        checks++;
        if (overrun !== 1'b0) begin
            failures++;
            $display("FAIL bp_clr got=%b exp=0", overrun);
        end
    endtask

    task automatic test_frame_err();
        logic [5:0] seq;
        int fe0;
        seq = 6'b101101;
        fe0 = fe_seen;
        out_ready = 1'b1;
        for (int i = 5; i >= 0; i--) drive(seq[i], 1'b1);
        checks++;
        if (frame_err !== 1'b1) begin
            failures++;
            $display("FAIL ferr_pulse got=%b exp=1", frame_err);
        end
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL ferr_state got=%b/%b exp=0/0", out_valid, busy);
        end
        drive(1'b0, 1'b1);
        checks++;
        if (frame_err !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL ferr_after got=%b/%b exp=0/0", frame_err, busy);
        end
        checks++;
        if (fe_seen - fe0 !== 1) begin
            failures++;
            $display("FAIL ferr_count got=%0d exp=1", fe_seen - fe0);
        end
    endtask

    task automatic test_strobe_gaps();
        logic [6:0] bits;
        int n;
`ifdef SIPO_FRAME_RX_PARITY_EN
        bits = 7'b1011000;
        n = 7;
`else
        bits = 7'b0101100;
        n = 6;
`endif
        out_ready = 1'b1;
        for (int i = n - 1; i >= 0; i--) begin
            drive(1'($urandom_range(0, 1)), 1'b0);
            drive(1'($urandom_range(0, 1)), 1'b0);
            if (i == n - 3) begin
                checks++;
                if (busy !== 1'b1) begin
                    failures++;
                    $display("FAIL gap_busy got=%b exp=1", busy);
                end
            end
            drive(bits[i], 1'b1);
        end
        checks++;
        if (out_valid !== 1'b1 || out_data !== 4'h6) begin
            failures++;
            $display("FAIL gap_word got=%b/%h exp=1/6", out_valid, out_data);
        end
        drive(1'b0, 1'b0);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL gap_consume got=%b exp=0", out_valid);
        end
    endtask

    task automatic test_reset_mid_frame();
        int fe0;
        fe0 = fe_seen;
        out_ready = 1'b1;
        drive(1'b1, 1'b1);
        drive(1'b1, 1'b1);
        drive(1'b0, 1'b1);
        reset_n = 1'b0;
        drive(1'b1, 1'b1);
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL mid_rst got=%b/%b exp=0/0", busy, out_valid);
        end
        reset_n = 1'b1;
        send_frame(4'h3, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 4'h3) begin
            failures++;
            $display("FAIL mid_word got=%b/%h exp=1/3", out_valid, out_data);
        end
        checks++;
        if (fe_seen !== fe0) begin
            failures++;
            $display("FAIL mid_ferr got=%0d exp=%0d", fe_seen, fe0);
        end
        drive(1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        send_frame(4'h9, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 4'h9) begin
            failures++;
            $display("FAIL b2b_first got=%b/%h exp=1/9", out_valid, out_data);
        end
        send_frame(4'hC, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 4'hC) begin
            failures++;
            $display("FAIL b2b_second got=%b/%h exp=1/c", out_valid, out_data);
        end
        drive(1'b0, 1'b0);
    endtask

`ifdef SIPO_FRAME_RX_PARITY_EN
    task automatic test_parity();
        logic [6:0] good;
        logic [5:0] bad;
        good = 7'b1101000;
        bad  = 6'b110101;
        out_ready = 1'b1;
        for (int i = 6; i >= 0; i--) drive(good[i], 1'b1);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 4'hA) begin
            failures++;
            $display("FAIL par_good got=%b/%h exp=1/a", out_valid, out_data);
        end
        drive(1'b0, 1'b0);
        for (int i = 5; i >= 0; i--) drive(bad[i], 1'b1);
        checks++;
        if (frame_err !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL par_bad got=%b/%b exp=1/0", frame_err, out_valid);
        end
        drive(1'b0, 1'b1);
        checks++;
        if (frame_err !== 1'b0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL par_after got=%b/%b exp=0/0", frame_err, out_valid);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_good_frame();
        test_backpressure();
        test_frame_err();
        test_strobe_gaps();
        test_reset_mid_frame();
        test_back_to_back();
`ifdef SIPO_FRAME_RX_PARITY_EN
        test_parity();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
